// File: rtl/runahead_event_source.sv
// Runahead difftest event source: tracks runahead mode, hands out monotonic
// checkpoint IDs to branches, keeps outstanding checkpoints in a circular
// table and emits one instruction or replay event per cycle to the sink.
module runahead_event_source #(
   parameter int unsigned DEPTH    = 8,
   parameter logic [7:0]  CORE_ID  = 8'd0,
   parameter logic [7:0]  LANE_IDX = 8'd0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ra_enter,
   input  logic        ra_exit,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_pc,
   input  logic        in_branch,
   input  logic        in_may_replay,
   input  logic        rs_valid,
   input  logic        rb_valid,
   input  logic [63:0] rb_id,
   output logic [7:0]  ev_coreid,
   output logic [7:0]  ev_index,
   output logic        ev_valid,
   output logic        ev_branch,
   output logic        ev_may_replay,
   output logic [63:0] ev_pc,
   output logic [63:0] ev_checkpoint_id,
   output logic        err
);

   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned AW = 64;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state;
   logic [AW-1:0]   oldest_id;
   logic [AW-1:0]   next_id;
   logic [AW-1:0]   slots [DEPTH];

   logic [AW-1:0]   count;
   logic [AW-1:0]   oldest_after_rs;
   logic [AW-1:0]   instr_id;
   logic            full;
   logic            rs_ok;
   logic            rb_legal;
   logic            exit_now;
   logic            accept;

   assign ev_coreid = CORE_ID;
   assign ev_index  = LANE_IDX;

   // Occupancy and handshake; full is taken before any same-cycle resolve.
   assign count           = next_id - oldest_id;
   assign full            = (count == AW'(DEPTH));
   assign in_ready        = (state == RUN) & ~full & ~rb_valid;
   assign exit_now        = (state == RUN) & ra_exit;
   assign accept          = in_valid & in_ready & ~ra_exit;
   assign rs_ok           = rs_valid & (count != '0);
   assign oldest_after_rs = oldest_id + AW'(rs_ok);
   assign rb_legal        = (rb_id >= oldest_after_rs) && (rb_id < next_id);
   assign instr_id        = in_branch ? next_id
                          : ((count != '0) ? (next_id - AW'(1)) : '0);

   // Mode FSM, checkpoint bookkeeping and registered event payload.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         oldest_id        <= AW'(1);
         next_id          <= AW'(1);
         ev_valid         <= 1'b0;
         ev_branch        <= 1'b0;
         ev_may_replay    <= 1'b0;
         ev_pc            <= '0;
         ev_checkpoint_id <= '0;
         err              <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) slots[i] <= '0;
      end else begin
         ev_valid <= 1'b0;
         if (exit_now) begin
            // Leaving runahead flushes all checkpoints; IDs are never reused.
            state     <= IDLE;
            oldest_id <= next_id;
         end else begin
            if (state == IDLE && ra_enter) state <= RUN;
            if (rs_valid) begin
               if (rs_ok) oldest_id <= oldest_after_rs;
               else       err       <= 1'b1;
            end
            if (state == RUN && rb_valid) begin
               if (rb_legal) begin
                  next_id          <= rb_id + AW'(1);
                  ev_valid         <= 1'b1;
                  ev_branch        <= 1'b1;
                  ev_may_replay    <= 1'b1;
                  ev_pc            <= slots[rb_id[IW-1:0]];
                  ev_checkpoint_id <= rb_id;
               end else begin
                  err <= 1'b1;
               end
            end else if (accept) begin
               if (in_branch) begin
                  slots[next_id[IW-1:0]] <= in_pc;
                  next_id                <= next_id + AW'(1);
               end
               ev_valid         <= 1'b1;
               ev_branch        <= in_branch;
               ev_may_replay    <= in_may_replay;
               ev_pc            <= in_pc;
               ev_checkpoint_id <= instr_id;
            end
         end
      end
   end

endmodule

// File: tb/tb_runahead_event_source.sv
// Directed bench for runahead_event_source with hand-computed expectations.
module tb_runahead_event_source;

   logic        clock = 1'b0;
   logic        reset;
   logic        ra_enter, ra_exit, in_valid, in_branch, in_may_replay;
   logic        rs_valid, rb_valid;
   logic [63:0] in_pc, rb_id;
   logic        in_ready, ev_valid, ev_branch, ev_may_replay, err;
   logic [7:0]  ev_coreid, ev_index;
   logic [63:0] ev_pc, ev_checkpoint_id;

   int n_checks = 0;
   int n_fail   = 0;

   runahead_event_source dut (
      .clock(clock), .reset(reset),
      .ra_enter(ra_enter), .ra_exit(ra_exit),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_branch(in_branch), .in_may_replay(in_may_replay),
      .rs_valid(rs_valid), .rb_valid(rb_valid), .rb_id(rb_id),
      .ev_coreid(ev_coreid), .ev_index(ev_index), .ev_valid(ev_valid),
      .ev_branch(ev_branch), .ev_may_replay(ev_may_replay),
      .ev_pc(ev_pc), .ev_checkpoint_id(ev_checkpoint_id), .err(err)
   );

   always #5 clock = ~clock;

   // Count one comparison and report it when observed differs from expected.
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; land 1 time unit after the rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Offer one instruction, expect acceptance and the matching event next cycle.
   task automatic issue(input string tag, input logic [63:0] pc, input logic br,
                        input logic mr, input logic [63:0] id);
      in_valid = 1'b1; in_pc = pc; in_branch = br; in_may_replay = mr;
      #1;
      check({tag, "_ready"}, 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0; in_branch = 1'b0; in_may_replay = 1'b0;
      check({tag, "_valid"}, 64'(ev_valid), 64'd1);
      check({tag, "_pc"}, ev_pc, pc);
      check({tag, "_id"}, ev_checkpoint_id, id);
      check({tag, "_br"}, 64'(ev_branch), 64'(br));
      check({tag, "_mr"}, 64'(ev_may_replay), 64'(mr));
   endtask

   task automatic pulse_enter();
      ra_enter = 1'b1; step(); ra_enter = 1'b0;
   endtask

   task automatic pulse_exit();
      ra_exit = 1'b1; step(); ra_exit = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      ra_enter = 0; ra_exit = 0; in_valid = 0; in_branch = 0; in_may_replay = 0;
      rs_valid = 0; rb_valid = 0; in_pc = '0; rb_id = '0;
      repeat (3) step();

      // Reset state
      check("rst_ev_valid", 64'(ev_valid), 64'd0);
      check("rst_ev_pc", ev_pc, 64'd0);
      check("rst_ev_id", ev_checkpoint_id, 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd0);
      check("rst_coreid", 64'(ev_coreid), 64'd0);
      check("rst_index", 64'(ev_index), 64'd0);
      reset = 1'b1;
      step();

      // IDLE: no acceptance
      in_valid = 1'b1; #1;
      check("idle_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      pulse_enter();

      // Non-branch instructions with no checkpoints carry id 0
      issue("nb0", 64'h8000_0000, 1'b0, 1'b0, 64'd0);
      issue("nb1", 64'h8000_0004, 1'b0, 1'b1, 64'd0);
      issue("nb2", 64'h8000_0008, 1'b0, 1'b0, 64'd0);
      step();
      check("idle_cycle_valid", 64'(ev_valid), 64'd0);
      check("hold_pc", ev_pc, 64'h8000_0008);

      // Fill all 8 checkpoint slots: ids 1..8
      for (int i = 1; i <= 8; i++)
         issue($sformatf("fill%0d", i), 64'h1000 + 64'(i * 4), 1'b1, 1'b0, 64'(i));
      in_valid = 1'b1; in_branch = 1'b1; in_pc = 64'h2000; #1;
      check("full_ready", 64'(in_ready), 64'd0);

      // Alloc + resolve at full: not taken, count drops to 7
      rs_valid = 1'b1; #1;
      check("full_rs_ready", 64'(in_ready), 64'd0);
      step();
      rs_valid = 1'b0; in_valid = 1'b0; in_branch = 1'b0;
      check("full_rs_noev", 64'(ev_valid), 64'd0);
      #1;
      check("after_rs_ready", 64'(in_ready), 64'd1);
      issue("br9", 64'h2000, 1'b1, 1'b0, 64'd9);

      // Exit flushes; re-enter continues IDs at 10
      pulse_exit();
      in_valid = 1'b1; #1;
      check("exit_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      check("exit_err", 64'(err), 64'd0);
      pulse_enter();

      // Branch ids 10..13 at pc 0x100..0x10c, then a non-branch tagged 13
      for (int i = 0; i < 4; i++)
         issue($sformatf("rbsetup%0d", i), 64'h100 + 64'(i * 4), 1'b1, 1'b0, 64'(10 + i));
      issue("nb_cnt", 64'h300, 1'b0, 1'b0, 64'd13);

      // Legal rollback to id 11 -> replay event of pc 0x104
      rb_valid = 1'b1; rb_id = 64'd11; in_valid = 1'b1; #1;
      check("rb_ready", 64'(in_ready), 64'd0);
      step();
      rb_valid = 1'b0; in_valid = 1'b0;
      check("rb_valid_ev", 64'(ev_valid), 64'd1);
      check("rb_pc", ev_pc, 64'h104);
      check("rb_id", ev_checkpoint_id, 64'd11);
      check("rb_br", 64'(ev_branch), 64'd1);
      check("rb_mr", 64'(ev_may_replay), 64'd1);
      check("rb_err", 64'(err), 64'd0);
      issue("after_rb", 64'h200, 1'b1, 1'b0, 64'd12);

      // Illegal rollback: no event, err set, ids unchanged
      rb_valid = 1'b1; rb_id = 64'd30; step(); rb_valid = 1'b0;
      check("rb_bad_noev", 64'(ev_valid), 64'd0);
      check("rb_bad_err", 64'(err), 64'd1);
      issue("rb_bad_nb", 64'h304, 1'b0, 1'b0, 64'd12);

      // Exit with 3 outstanding (10..12), re-enter: next branch is 13
      pulse_exit();
      pulse_enter();
      issue("reenter_br", 64'h400, 1'b1, 1'b0, 64'd13);

      // Reset mid-operation drops the pending event
      in_valid = 1'b1; in_branch = 1'b1; in_pc = 64'h500; #2;
      reset = 1'b0; #1;
      check("midrst_valid", 64'(ev_valid), 64'd0);
      check("midrst_err", 64'(err), 64'd0);
      check("midrst_pc", ev_pc, 64'd0);
      in_valid = 1'b0; in_branch = 1'b0;
      step();
      reset = 1'b1;
      step();

      // Resolve with no checkpoints sets err
      pulse_enter();
      rs_valid = 1'b1; step(); rs_valid = 1'b0;
      check("rs_empty_err", 64'(err), 64'd1);
      check("rs_empty_noev", 64'(ev_valid), 64'd0);
      issue("post_rst_br", 64'h600, 1'b1, 1'b1, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
